grf_multiport_sb: RTL and testbench
===================================

// Module: grf_multiport_sb
// PURPOSE
//  Parametrised general-purpose register file for the decode stage; successor to the 2R/1W GRF.
//  - NUM_RD read ports and NUM_WR write ports, with same-cycle write-to-read bypass.
//  - Built-in busy-bit scoreboard so decode can detect pending producers and stall.
//  - Registered per-port commit trace (pc/addr/data) for the testbench and debug checker.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W   5  register index width; DEPTH = 2**ADDR_W entries
//  NUM_RD   2  number of read ports
//  NUM_WR   2  number of write ports; a higher index means higher priority
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               asynchronous reset, active low
//  raddr        in   NUM_RD*ADDR_W   read addresses, port r at bits [r*ADDR_W +: ADDR_W]
//  rdata        out  NUM_RD*DATA_W   read data, combinational, bypassed
//  rbusy        out  NUM_RD          register at raddr[r] has a pending producer
//  we           in   NUM_WR          write enable per port
//  waddr        in   NUM_WR*ADDR_W   write addresses
//  wdata        in   NUM_WR*DATA_W   write data
//  wpc          in   NUM_WR*32       pc of the committing instruction (trace only)
//  wclr         in   NUM_WR          this write also clears the busy bit of waddr
//  iss_valid    in   1               issue: mark iss_addr busy
//  iss_addr     in   ADDR_W          destination of the issued instruction
//  sb_flush     in   1               clear all busy bits (pipeline flush)
//  busy_cnt     out  ADDR_W+1        registered count of busy entries
//  trc_valid    out  NUM_WR          registered: port w committed an effective write last cycle
//  trc_addr     out  NUM_WR*ADDR_W   registered commit address per port
//  trc_data     out  NUM_WR*DATA_W   registered commit data per port
//  trc_pc       out  NUM_WR*32       registered commit pc per port
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//  - All entries 0, busy[] 0, busy_cnt 0, trc_* 0.
//  - rdata still reflects the cleared array; bypass remains active during reset.
//  Register 0
//  - Reads always return 0. Writes to 0 are ignored: no trace, no busy change. Entry 0 is never busy.
//  Writes
//  - Effective write: we[w] && waddr[w]!=0. It commits at posedge.
//  - Several ports writing the same address in one cycle: the highest index w wins.
//  Read bypass
//  - rdata[r] = wdata of the highest-index effective write with waddr==raddr[r]; otherwise array[raddr[r]].
//  - Zero added latency: combinational in the same cycle.
//  Scoreboard (updated at posedge, in this priority order)
//  - sb_flush: busy <= 0. An iss_valid in the same cycle is dropped; writes still commit.
//  - Otherwise, each effective write with wclr[w] clears busy[waddr[w]].
//  - Then iss_valid && iss_addr!=0 sets busy[iss_addr]. Set wins over clear on the same address (newer producer).
//  - rbusy[r] = busy[raddr[r]], except 0 when any effective wclr write targets raddr[r] this cycle (value is bypassed).
//  - rbusy[r] = 0 when raddr[r]==0.
//  - busy_cnt = popcount of busy[] as registered after the update. Range 0..DEPTH-1; it cannot wrap.
//  Trace
//  - One-cycle latency: trc_valid[w] <= effective write on port w; trc_addr/trc_data/trc_pc capture the inputs.
//  - Trace is reported per port even when that port loses the same-address priority (the checker sees both).
//  - trc_valid deasserts the cycle after the write unless a new write occurs.
//  Reset asserted mid-operation
//  - Pending writes are lost and busy is cleared immediately; trc_valid drops asynchronously.
// STRUCTURE
//  - Package grf_pkg: DATA_W/ADDR_W defaults, typedef reg_idx_t, typedef reg_word_t, localparam REG_ZERO.
//  - Sub-module grf_scoreboard (DEPTH, NUM_WR, NUM_RD): holds busy[], the priority update, rbusy and busy_cnt.
//  - Top level holds the storage array, the write arbitration/bypass muxes and the trace registers.
// TESTING
//  1 Reset: drive rst_n=0 mid-run after writing 0xDEADBEEF to r5 -> rdata(r5)=0, busy_cnt=0, trc_valid=0 with no clock edge.
//  2 Bypass and priority: we=2'b11, waddr r7/r7, wdata 0x11/0x22, raddr0=r7 -> rdata0=0x22 in the same cycle;
//    r7 reads 0x22 next cycle; trc_valid=2'b11 for one cycle.
//  3 Register 0: write 0xFFFF_FFFF to r0 with wclr=1 -> rdata(r0)=0, trc_valid=0, rbusy=0; iss to r0 -> busy_cnt unchanged.
//  4 Scoreboard: iss r3 -> next cycle rbusy(r3)=1, busy_cnt=1.
//    Later write r3 with wclr while iss r3 in the same cycle -> r3 stays busy, busy_cnt=1, rdata bypassed.
//  5 Flush: set busy on r1,r2,r4 (busy_cnt=3), then sb_flush with iss r9 -> busy_cnt=0, rbusy(r9)=0.
//    A concurrent write to r4 commits.
//  6 Random: 10k cycles against a reference model; compare rdata, rbusy, busy_cnt and trc_* every cycle, NUM_RD=4, NUM_WR=3.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and defaults for the multi-port general-purpose register file.
package grf_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_ADDR_W = 5;

  typedef logic [GRF_ADDR_W-1:0] reg_idx_t;
  typedef logic [GRF_DATA_W-1:0] reg_word_t;

  // Hard-wired zero register index
  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/grf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending producer for decode stalls.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_eff,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR-1:0]        wclr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     sb_flush,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  // Next busy vector: flush beats everything, then clears, then the new issue
  always_comb begin
    busy_d = busy_q;
    if (sb_flush) begin
      busy_d = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w] && wclr[w]) busy_d[waddr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
      // A newer producer on the same register keeps it busy
      if (iss_valid && (iss_addr != Zero)) busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the post-update busy vector
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
  end

  // Busy state and its registered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Per-port busy lookup; a clearing write in flight already supplies the value
  always_comb begin
    rbusy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rbusy[r] = busy_q[raddr[r*ADDR_W +: ADDR_W]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w] && wclr[w] &&
            (waddr[w*ADDR_W +: ADDR_W] == raddr[r*ADDR_W +: ADDR_W])) begin
          rbusy[r] = 1'b0;
        end
      end
      if (raddr[r*ADDR_W +: ADDR_W] == Zero) rbusy[r] = 1'b0;
    end
  end

endmodule

// File: rtl/grf_multiport_sb.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and commit trace.
module grf_multiport_sb
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR*32-1:0]     wpc,
  input  logic [NUM_WR-1:0]        wclr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     sb_flush,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [NUM_WR-1:0]        trc_valid,
  output logic [NUM_WR*ADDR_W-1:0] trc_addr,
  output logic [NUM_WR*DATA_W-1:0] trc_data,
  output logic [NUM_WR*32-1:0]     trc_pc
);

  localparam int unsigned         DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]   Zero  = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_WR-1:0] wr_eff;

  // A write is effective only when enabled and not aimed at the zero register
  always_comb begin
    wr_eff = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_eff[w] = we[w] && (waddr[w*ADDR_W +: ADDR_W] != Zero);
    end
  end

  // Storage; later ports are applied last so the highest index wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w]) mem_q[waddr[w*ADDR_W +: ADDR_W]] <= wdata[w*DATA_W +: DATA_W];
      end
    end
  end

  // Read muxes with same-cycle bypass from the highest-index matching write
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rdata[r*DATA_W +: DATA_W] = mem_q[raddr[r*ADDR_W +: ADDR_W]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w] && (waddr[w*ADDR_W +: ADDR_W] == raddr[r*ADDR_W +: ADDR_W])) begin
          rdata[r*DATA_W +: DATA_W] = wdata[w*DATA_W +: DATA_W];
        end
      end
      if (raddr[r*ADDR_W +: ADDR_W] == Zero) rdata[r*DATA_W +: DATA_W] = '0;
    end
  end

  // Commit trace: every effective write is reported on its own port, winner or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trc_valid <= '0;
      trc_addr  <= '0;
      trc_data  <= '0;
      trc_pc    <= '0;
    end else begin
      trc_valid <= wr_eff;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w]) begin
          trc_addr[w*ADDR_W +: ADDR_W] <= waddr[w*ADDR_W +: ADDR_W];
          trc_data[w*DATA_W +: DATA_W] <= wdata[w*DATA_W +: DATA_W];
          trc_pc[w*32 +: 32]           <= wpc[w*32 +: 32];
        end
      end
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_eff    (wr_eff),
    .waddr     (waddr),
    .wclr      (wclr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .sb_flush  (sb_flush),
    .raddr     (raddr),
    .rbusy     (rbusy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_grf_multiport_sb.sv
// Bench for grf_multiport_sb: directed scenarios plus randomized traffic against a reference model.
module tb_grf_multiport_sb;

  localparam int NR = 4;
  localparam int NW = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NW*32-1:0]  wpc;
  logic [NW-1:0]     wclr;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              sb_flush;
  logic [AW:0]       busy_cnt;
  logic [NW-1:0]     trc_valid;
  logic [NW*AW-1:0]  trc_addr;
  logic [NW*DW-1:0]  trc_data;
  logic [NW*32-1:0]  trc_pc;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grf_multiport_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wpc       (wpc),
    .wclr      (wclr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .sb_flush  (sb_flush),
    .busy_cnt  (busy_cnt),
    .trc_valid (trc_valid),
    .trc_addr  (trc_addr),
    .trc_data  (trc_data),
    .trc_pc    (trc_pc)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_tv   [NW];
  logic [4:0]  m_ta   [NW];
  logic [31:0] m_td   [NW];
  logic [31:0] m_tp   [NW];

  function automatic logic [4:0] wa(int w);
    return waddr[w*AW +: AW];
  endfunction

  function automatic logic [31:0] wd(int w);
    return wdata[w*DW +: DW];
  endfunction

  function automatic logic [4:0] ra(int r);
    return raddr[r*AW +: AW];
  endfunction

  function automatic bit eff(int w);
    return we[w] && (wa(w) != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rdata(int r);
    logic [31:0] v;
    if (ra(r) == 5'd0) return 32'd0;
    v = m_mem[ra(r)];
    for (int w = 0; w < NW; w++) if (eff(w) && wa(w) == ra(r)) v = wd(w);
    return v;
  endfunction

  function automatic bit exp_rbusy(int r);
    if (ra(r) == 5'd0) return 1'b0;
    for (int w = 0; w < NW; w++) if (eff(w) && wclr[w] && wa(w) == ra(r)) return 1'b0;
    return m_busy[ra(r)];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    for (int w = 0; w < NW; w++) begin
      m_tv[w] = 1'b0;
      m_ta[w] = 5'd0;
      m_td[w] = 32'd0;
      m_tp[w] = 32'd0;
    end
  endtask

  // Applies one clock edge worth of architectural effects using the current inputs
  task automatic model_step();
    for (int w = 0; w < NW; w++) begin
      m_tv[w] = eff(w);
      if (eff(w)) begin
        m_ta[w] = wa(w);
        m_td[w] = wd(w);
        m_tp[w] = wpc[w*32 +: 32];
      end
    end
    for (int w = 0; w < NW; w++) if (eff(w)) m_mem[wa(w)] = wd(w);
    if (sb_flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) if (eff(w) && wclr[w]) m_busy[wa(w)] = 1'b0;
      if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rdata%0d", r), 64'(rdata[r*DW +: DW]), 64'(exp_rdata(r)));
      chk($sformatf("rbusy%0d", r), 64'(rbusy[r]), 64'(exp_rbusy(r)));
    end
    chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    for (int w = 0; w < NW; w++) begin
      chk($sformatf("trc_valid%0d", w), 64'(trc_valid[w]), 64'(m_tv[w]));
      if (m_tv[w]) begin
        chk($sformatf("trc_addr%0d", w), 64'(trc_addr[w*AW +: AW]), 64'(m_ta[w]));
        chk($sformatf("trc_data%0d", w), 64'(trc_data[w*DW +: DW]), 64'(m_td[w]));
        chk($sformatf("trc_pc%0d", w), 64'(trc_pc[w*32 +: 32]), 64'(m_tp[w]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    raddr     = '0;
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    wpc       = '0;
    wclr      = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    sb_flush  = 1'b0;
  endtask

  task automatic set_wr(int w, logic [4:0] a, logic [31:0] d, bit clr);
    we[w]              = 1'b1;
    waddr[w*AW +: AW]  = a;
    wdata[w*DW +: DW]  = d;
    wpc[w*32 +: 32]    = 32'h0000_1000 + 32'(w * 4);
    wclr[w]            = clr;
  endtask

  task automatic set_rd(int r, logic [4:0] a);
    raddr[r*AW +: AW] = a;
  endtask

  task automatic iss(logic [4:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    n_vec++;
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("reset trc_valid", 64'(trc_valid), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: asynchronous reset mid-run
    idle();
    set_wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    iss(5'd6);
    step();
    idle();
    set_rd(0, 5'd5);
    #1;
    chk("t1 rdata r5", 64'(rdata[31:0]), 64'hDEAD_BEEF);
    chk("t1 busy_cnt", 64'(busy_cnt), 64'd1);
    chk("t1 trc_valid", 64'(trc_valid), 64'b001);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1 async rdata r5", 64'(rdata[31:0]), 64'd0);
    chk("t1 async busy_cnt", 64'(busy_cnt), 64'd0);
    chk("t1 async trc_valid", 64'(trc_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // 2: bypass and same-address priority
    idle();
    set_wr(0, 5'd7, 32'h11, 1'b0);
    set_wr(1, 5'd7, 32'h22, 1'b0);
    set_rd(0, 5'd7);
    #1;
    chk("t2 bypass", 64'(rdata[31:0]), 64'h22);
    step();
    idle();
    set_rd(0, 5'd7);
    #1;
    chk("t2 stored", 64'(rdata[31:0]), 64'h22);
    chk("t2 trc_valid", 64'(trc_valid), 64'b011);
    step();
    chk("t2 trc_valid drop", 64'(trc_valid), 64'd0);

    // 3: register zero
    idle();
    set_wr(0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    set_rd(0, 5'd0);
    #1;
    chk("t3 rdata r0", 64'(rdata[31:0]), 64'd0);
    chk("t3 rbusy r0", 64'(rbusy[0]), 64'd0);
    step();
    chk("t3 trc_valid", 64'(trc_valid), 64'd0);
    idle();
    iss(5'd0);
    step();
    chk("t3 busy_cnt", 64'(busy_cnt), 64'd0);

    // 4: scoreboard set beats clear
    idle();
    iss(5'd3);
    step();
    idle();
    set_rd(0, 5'd3);
    #1;
    chk("t4 rbusy r3", 64'(rbusy[0]), 64'd1);
    chk("t4 busy_cnt", 64'(busy_cnt), 64'd1);
    set_wr(0, 5'd3, 32'h33, 1'b1);
    iss(5'd3);
    #1;
    chk("t4 bypass r3", 64'(rdata[31:0]), 64'h33);
    chk("t4 rbusy clr", 64'(rbusy[0]), 64'd0);
    step();
    idle();
    set_rd(0, 5'd3);
    #1;
    chk("t4 rbusy again", 64'(rbusy[0]), 64'd1);
    chk("t4 busy_cnt again", 64'(busy_cnt), 64'd1);

    // 5: flush drops concurrent issue, keeps concurrent write
    idle();
    sb_flush = 1'b1;
    step();
    idle(); iss(5'd1); step();
    idle(); iss(5'd2); step();
    idle(); iss(5'd4); step();
    idle();
    #1;
    chk("t5 busy_cnt 3", 64'(busy_cnt), 64'd3);
    sb_flush = 1'b1;
    iss(5'd9);
    set_wr(1, 5'd4, 32'h44, 1'b0);
    step();
    idle();
    set_rd(0, 5'd9);
    set_rd(1, 5'd4);
    #1;
    chk("t5 busy_cnt 0", 64'(busy_cnt), 64'd0);
    chk("t5 rbusy r9", 64'(rbusy[0]), 64'd0);
    chk("t5 rdata r4", 64'(rdata[63:32]), 64'h44);

    // 6: randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 10000; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      for (int r = 0; r < NR; r++) set_rd(r, rnd_addr());
      for (int w = 0; w < NW; w++) begin
        we[w]             = ($urandom_range(0, 1) == 1);
        waddr[w*AW +: AW] = rnd_addr();
        wdata[w*DW +: DW] = $urandom;
        wpc[w*32 +: 32]   = $urandom;
        wclr[w]           = ($urandom_range(0, 2) != 0);
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_addr  = rnd_addr();
      sb_flush  = ($urandom_range(0, 31) == 0);
      step();
    end

    idle();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
